// File: rtl/seg_scan_display_if.sv
// Bus between the status-register side and the 7-segment scan driver.
// With SEG_SCAN_BLINK_EN defined the bus also carries the per-digit blink mask.
interface seg_scan_display_if #(
   parameter int unsigned DIGITS = 8,
   parameter int unsigned SEL_W  = $clog2(DIGITS)
);
   logic [4*DIGITS-1:0] data;
   logic [DIGITS-1:0]   dp;
   logic [DIGITS-1:0]   blank;
   logic                load;
   logic                lz_en;
   logic [3:0]          brightness;
   logic [SEL_W-1:0]    which;
   logic [7:0]          seg;
   logic                frame_start;
`ifdef SEG_SCAN_BLINK_EN
   logic [DIGITS-1:0]   blink;

   modport master (
      output data, dp, blank, load, lz_en, brightness, blink,
      input  which, seg, frame_start
   );
   modport slave (
      input  data, dp, blank, load, lz_en, brightness, blink,
      output which, seg, frame_start
   );
`else
   modport master (
      output data, dp, blank, load, lz_en, brightness,
      input  which, seg, frame_start
   );
   modport slave (
      input  data, dp, blank, load, lz_en, brightness,
      output which, seg, frame_start
   );
`endif
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scan driver: frame-synchronous shadow loading, dp/blank masks,
// leading-zero suppression, 16-level PWM. Optional blink feature: define SEG_SCAN_BLINK_EN.
module seg_scan_display #(
   parameter int unsigned DIGITS     = 8,
   parameter int unsigned SCAN_LOG2  = 10,
   parameter bit          ACTIVE_LOW = 1'b1,
   parameter int unsigned SEL_W      = $clog2(DIGITS)
`ifdef SEG_SCAN_BLINK_EN
   ,
   parameter int unsigned BLINK_LOG2 = 6
`endif
) (
   input  logic clk,
   input  logic rst,
   seg_scan_display_if.slave disp
);

   logic [SCAN_LOG2-1:0] cnt, cnt_n;
   logic [SEL_W-1:0]     which_q, which_n;
   logic [7:0]           seg_q, seg_n;
   logic                 fs_q;
   logic                 pending, pending_n;
   logic [4*DIGITS-1:0]  sh_data, sh_data_n, cm_data, cm_data_n;
   logic [DIGITS-1:0]    sh_dp, sh_dp_n, cm_dp, cm_dp_n;
   logic [DIGITS-1:0]    sh_blank, sh_blank_n, cm_blank, cm_blank_n;
   logic                 tick, wrap;
   logic                 zero_run, lz_dark, dp_bit, dark, lit;
   logic [3:0]           nib;
   logic [7:0]           on;
`ifdef SEG_SCAN_BLINK_EN
   logic [BLINK_LOG2-1:0] fcnt, fcnt_n;
`endif

   function automatic logic [6:0] glyph(input logic [3:0] v);
      case (v)
         4'h0:    glyph = 7'b1111110;
         4'h1:    glyph = 7'b0110000;
         4'h2:    glyph = 7'b1101101;
         4'h3:    glyph = 7'b1111001;
         4'h4:    glyph = 7'b0110011;
         4'h5:    glyph = 7'b1011011;
         4'h6:    glyph = 7'b1011111;
         4'h7:    glyph = 7'b1110000;
         4'h8:    glyph = 7'b1111111;
         4'h9:    glyph = 7'b1111011;
         4'hA:    glyph = 7'b1110111;
         4'hB:    glyph = 7'b0011111;
         4'hC:    glyph = 7'b1001110;
         4'hD:    glyph = 7'b0111101;
         4'hE:    glyph = 7'b1001111;
         default: glyph = 7'b1000111;
      endcase
   endfunction

   assign tick = &cnt;
   assign wrap = tick && (which_q == SEL_W'(DIGITS - 1));

   // seg is decoded from the next-state values (which, cnt, committed data) so the
   // registered seg and which always describe the same digit slot and PWM phase.
   always_comb begin
      cnt_n   = cnt + SCAN_LOG2'(1);
      which_n = which_q;
      if (tick) which_n = wrap ? '0 : which_q + SEL_W'(1);

      sh_data_n  = disp.load ? disp.data  : sh_data;
      sh_dp_n    = disp.load ? disp.dp    : sh_dp;
      sh_blank_n = disp.load ? disp.blank : sh_blank;
      pending_n  = pending | disp.load;
      cm_data_n  = cm_data;
      cm_dp_n    = cm_dp;
      cm_blank_n = cm_blank;
      // A load on the wrap tick goes straight through the shadow into the committed set.
      if (wrap && pending_n) begin
         cm_data_n  = sh_data_n;
         cm_dp_n    = sh_dp_n;
         cm_blank_n = sh_blank_n;
         pending_n  = 1'b0;
      end
`ifdef SEG_SCAN_BLINK_EN
      // Advances on the same edge that raises frame_start.
      fcnt_n = wrap ? fcnt + BLINK_LOG2'(1) : fcnt;
`endif

      zero_run = 1'b1;
      lz_dark  = 1'b0;
      dp_bit   = 1'b0;
      dark     = 1'b0;
      nib      = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         zero_run = zero_run & (cm_data_n[4*(DIGITS-1-i) +: 4] == 4'h0);
         if (SEL_W'(i) == which_n) begin
            nib     = cm_data_n[4*(DIGITS-1-i) +: 4];
            dp_bit  = cm_dp_n[DIGITS-1-i];
            dark    = cm_blank_n[DIGITS-1-i];
            lz_dark = disp.lz_en & zero_run & (i < DIGITS - 1);
`ifdef SEG_SCAN_BLINK_EN
            dark    = dark | (disp.blink[DIGITS-1-i] & fcnt_n[BLINK_LOG2-1]);
`endif
         end
      end

      lit = cnt_n[SCAN_LOG2-1 -: 4] <= disp.brightness;
      on  = {lz_dark ? 7'h00 : glyph(nib), dp_bit};
      if (dark || !lit) on = '0;
      seg_n = ACTIVE_LOW ? ~on : on;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         which_q  <= '0;
         seg_q    <= {8{ACTIVE_LOW}};
         fs_q     <= 1'b0;
         pending  <= 1'b0;
         sh_data  <= '0;
         sh_dp    <= '0;
         sh_blank <= '1;
         cm_data  <= '0;
         cm_dp    <= '0;
         cm_blank <= '1;
`ifdef SEG_SCAN_BLINK_EN
         fcnt     <= '0;
`endif
      end else begin
         cnt      <= cnt_n;
         which_q  <= which_n;
         seg_q    <= seg_n;
         fs_q     <= wrap;
         pending  <= pending_n;
         sh_data  <= sh_data_n;
         sh_dp    <= sh_dp_n;
         sh_blank <= sh_blank_n;
         cm_data  <= cm_data_n;
         cm_dp    <= cm_dp_n;
         cm_blank <= cm_blank_n;
`ifdef SEG_SCAN_BLINK_EN
         fcnt     <= fcnt_n;
`endif
      end
   end

   assign disp.which       = which_q;
   assign disp.seg         = seg_q;
   assign disp.frame_start = fs_q;

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised multiplexed 7-segment scan driver; successor to the fixed 8-digit scanner.
- Adds: digit count and scan rate as parameters; synchronous reset; frame-synchronous shadow loading (no tearing); per-digit decimal point and blank masks; leading-zero suppression; 16-level PWM brightness.
- Sits between the CPU debug/status registers and the board's digit-select and segment pins.

Parameters:
- DIGITS, 8: number of digits scanned (2..16).
- SCAN_LOG2, 10: each digit slot lasts 2**SCAN_LOG2 clk cycles; must be >= 4.
- ACTIVE_LOW, 1: 1 = seg outputs active-low; 0 = active-high.
- SEL_W, $clog2(DIGITS): width of the which port.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- data  in  4*DIGITS  hex nibbles; digit 0 = data[4*DIGITS-1 -: 4] (MS nibble).
- dp  in  DIGITS  decimal point per digit; bit DIGITS-1-i belongs to digit i.
- blank  in  DIGITS  force digit dark; same bit mapping as dp.
- load  in  1  capture data/dp/blank into the pending shadow this cycle.
- lz_en  in  1  leading-zero suppression enable (sampled live).
- brightness  in  4  PWM level; 0 = 1/16 duty, 15 = full.
- which  out  SEL_W  binary index of the digit currently driven.
- seg  out  8  segments {a,b,c,d,e,f,g,dp}: seg[7]=a ... seg[1]=g, seg[0]=dp.
- frame_start  out  1  one-cycle pulse when which wraps to 0.

Behaviour:
- Reset (rst=1 at clk edge): cnt=0, which=0, seg=all-off (8'hFF if ACTIVE_LOW, else 8'h00), frame_start=0, pending flag=0. Committed data, dp and shadow data = 0. Committed blank = all ones, so the display is dark until the first commit.
- Slot counter cnt is SCAN_LOG2 bits and free-running. Tick when cnt == all-ones.
- On a tick, which advances by 1. At DIGITS-1 it wraps to 0, and frame_start=1 on the following cycle only.
- Shadow: load=1 copies data/dp/blank into the shadow and sets pending.
- Commit: on a tick where which == DIGITS-1 (the wrap tick) and pending=1, shadow moves to committed and pending clears. The first slot of the new frame uses the new data.
- load on the same cycle as a wrap tick: the newly loaded value is captured into the shadow and committed in that same cycle. It is never lost or delayed a frame.
- Multiple loads within a frame: the last one wins.
- Digit value decode: 0-F uses standard hex glyphs. Lit segments for 0: a,b,c,d,e,f. For 1: b,c. For A: a,b,c,e,f,g. For b: c,d,e,f,g. For C: a,d,e,f. For d: b,c,d,e,g. For E: a,d,e,f,g. For F: a,e,f,g. Remaining digits use the usual patterns.
- Leading-zero suppression (lz_en=1): digit i is dark if every committed nibble of digits 0..i is 0 and i < DIGITS-1. The last digit is always shown. dp of a suppressed digit is still shown.
- Blank: a committed blank bit darkens the whole digit, including dp.
- PWM: phase = cnt[SCAN_LOG2-1 -: 4]. Segments are lit only while phase <= brightness; otherwise seg = all-off, while which keeps its value.
- Output timing: seg and which are registered. seg reflects the which value present on the same cycle, with no one-cycle skew between them.
- Outputs have no X after reset. brightness changes take effect on the next cycle.

Optional Feature:
- Macro SEG_SCAN_BLINK_EN.
- Defined: adds input blink[DIGITS-1:0] (same bit mapping as dp) and parameter BLINK_LOG2 (default 6), plus a BLINK_LOG2-bit frame counter that increments on each frame_start and resets to 0. A digit with blink=1 is dark whenever the counter MSB = 1. blink is sampled live, not shadowed.
- Undefined: no blink port, parameter or counter; behaviour is exactly as above.

Test Plan:
All scenarios use DIGITS=8, SCAN_LOG2=4 and ACTIVE_LOW=1.
- Reset: hold rst for 3 cycles, then release with no load. Require which=0, seg=8'hFF, and seg stays 8'hFF for 2 full frames (256 cycles); which steps 0..7 every 16 cycles.
- Load data=32'h0123_89AB, brightness=15, blank=0, dp=0, then wait for frame_start. Require: which=0 gives 8'b0000_0011, which=1 gives 8'b1001_1111, which=6 gives 8'b0001_0001 (A), which=7 gives 8'b1100_0001 (b).
- Mid-frame load of 32'hFFFF_FFFF while which=3. Require digits 3..7 of the current frame still show the old data; the new value appears starting at which=0 of the next frame. Also load exactly on the wrap tick and require commit in that same frame.
- lz_en=1 with data=32'h0000_0050. Require digits 0..5 = 8'hFF, digit 6 = 8'b0100_1001, digit 7 = 8'b0000_0011. With data=0, only digit 7 shows 8'b0000_0011.
- brightness=3. Require seg lit for cnt 0..3 of each 16-cycle slot (4 cycles) and 8'hFF for the other 12. With dp=8'h01 and data=0, digit 7 = 8'b0000_0010 while lit.
- Assert rst mid-frame at which=5. Require which=0, seg=8'hFF and pending cleared on the next cycle; a pre-reset pending load is never displayed.
